// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM encoding for the SPI register bank.
package spi_reg_pkg;

    localparam int ADDR_W        = 4;
    localparam int CMD_WRITE_BIT = 7;

    localparam logic [ADDR_W-1:0] ADDR_ID     = 4'd0;
    localparam logic [ADDR_W-1:0] ADDR_FAN    = 4'd1;
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 4'd2;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_t;

    function automatic logic is_writable(input logic [ADDR_W-1:0] a);
        return !(a == ADDR_ID || a == ADDR_STATUS);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer with rising-edge detect and a "chain flushed" flag
// that goes high once the output reflects real samples rather than the reset value.
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic sysclk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic valid
);

    logic [STAGES-1:0] chain;
    logic [STAGES-1:0] fill;
    logic              prev;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            chain <= {STAGES{RESET_VAL}};
            fill  <= '0;
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
            fill  <= {fill[STAGES-2:0], 1'b1};
            prev  <= chain[STAGES-1];
        end
    end

    assign sync_out = chain[STAGES-1];
    assign rise     = chain[STAGES-1] & ~prev;
    assign valid    = fill[STAGES-1];

endmodule

// File: rtl/spi_reg_bank.sv
// SPI-framed 16-entry register bank. Define SPI_REG_AUTOINC_EN for burst address increment.
// state | meaning: IDLE wait for CS low | CMD expect command byte | WRITE data bytes stored | READ bytes return reg data
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter logic [7:0] ID_VALUE    = 8'hA5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       rxReady,
    input  logic [7:0] rx,
    input  logic       spiCS,
    output logic       txReady,
    output logic [7:0] tx,
    output logic [7:0] fanDuty,
    output logic [7:0] ctrl,
    input  logic [7:0] status
);

`ifdef SPI_REG_AUTOINC_EN
    localparam logic [ADDR_W-1:0] ADDR_STEP = 4'd1;
`else
    localparam logic [ADDR_W-1:0] ADDR_STEP = 4'd0;
`endif

    logic rx_level_unused, rx_rise, rx_valid;
    logic cs_level, cs_rise, cs_valid;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_rx_sync (
        .sysclk(sysclk), .reset(reset), .async_in(rxReady),
        .sync_out(rx_level_unused), .rise(rx_rise), .valid(rx_valid)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .sysclk(sysclk), .reset(reset), .async_in(spiCS),
        .sync_out(cs_level), .rise(cs_rise), .valid(cs_valid)
    );

    state_t            state, state_next;
    logic              armed;
    logic              strobe;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [7:0]        regs [16];

    // CS high wins over a coincident byte strobe.
    assign strobe = rx_rise & rx_valid & ~cs_level;

    // A CS held low across reset must not open a frame until it has been seen high.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            armed <= armed | cs_rise | (cs_valid & cs_level);
        end
    end

    always_comb begin
        state_next = state;
        if (cs_level) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (armed) state_next = CMD;
                CMD:     if (strobe) state_next = rx[CMD_WRITE_BIT] ? WRITE : READ;
                default: state_next = state;
            endcase
        end
    end

    assign rd_addr = (state == CMD) ? rx[ADDR_W-1:0] : addr;

    always_comb begin
        case (rd_addr)
            ADDR_ID:     rd_data = ID_VALUE;
            ADDR_STATUS: rd_data = status;
            default:     rd_data = regs[rd_addr];
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            txReady <= 1'b0;
            tx      <= 8'h00;
            addr    <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
        end else begin
            txReady <= 1'b0;
            if (strobe) begin
                case (state)
                    CMD: begin
                        txReady <= 1'b1;
                        if (rx[CMD_WRITE_BIT]) begin
                            tx   <= 8'h00;
                            addr <= rx[ADDR_W-1:0];
                        end else begin
                            tx   <= rd_data;
                            addr <= rx[ADDR_W-1:0] + ADDR_STEP;
                        end
                    end
                    WRITE: begin
                        if (is_writable(addr)) regs[addr] <= rx;
                        tx      <= rx;
                        txReady <= 1'b1;
                        addr    <= addr + ADDR_STEP;
                    end
                    READ: begin
                        tx      <= rd_data;
                        txReady <= 1'b1;
                        addr    <= addr + ADDR_STEP;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign fanDuty = regs[ADDR_FAN];
    assign ctrl    = regs[ADDR_CTRL];

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: table frames, hand corner cases, random frames vs frame-level model.
module tb_spi_reg_bank;

    localparam int SS = 2;
`ifdef SPI_REG_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       sysclk = 1'b0;
    logic       reset, rxReady, spiCS, txReady;
    logic [7:0] rx, tx, fanDuty, ctrl, status;

    always #5 sysclk = ~sysclk;

    spi_reg_bank #(.ID_VALUE(8'hA5), .SYNC_STAGES(SS)) dut (
        .sysclk(sysclk), .reset(reset), .rxReady(rxReady), .rx(rx), .spiCS(spiCS),
        .txReady(txReady), .tx(tx), .fanDuty(fanDuty), .ctrl(ctrl), .status(status)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] txq[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_regs[16];

    always @(negedge sysclk) if (txReady) txq.push_back(tx);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] q_at(input int i);
        return (i < txq.size()) ? txq[i] : 8'hxx;
    endfunction

    function automatic logic [7:0] m_read(input logic [3:0] a);
        if (a == 4'd0) return 8'hA5;
        if (a == 4'd3) return status;
        return m_regs[a];
    endfunction

    // Frame-level reference: expected MISO bytes and register effects of one frame.
    task automatic model_frame(input logic [7:0] bytes[$]);
        logic [7:0] c;
        logic [3:0] a;
        exp_q.delete();
        c = bytes[0];
        a = c[3:0];
        if (c[7]) begin
            exp_q.push_back(8'h00);
            for (int i = 1; i < bytes.size(); i++) begin
                if (a != 4'd0 && a != 4'd3) m_regs[a] = bytes[i];
                exp_q.push_back(bytes[i]);
                if (AUTOINC) a = a + 4'd1;
            end
        end else begin
            for (int i = 0; i < bytes.size(); i++) begin
                exp_q.push_back(m_read(a));
                if (AUTOINC) a = a + 4'd1;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge sysclk);
        rx = b;
        rxReady = 1'b1;
        repeat (4) @(negedge sysclk);
        rxReady = 1'b0;
        repeat (4) @(negedge sysclk);
    endtask

    task automatic cs_low();
        @(negedge sysclk);
        txq.delete();
        spiCS = 1'b0;
        repeat (SS + 3) @(negedge sysclk);
    endtask

    task automatic cs_high();
        @(negedge sysclk);
        spiCS = 1'b1;
        repeat (SS + 3) @(negedge sysclk);
    endtask

    task automatic run_frame(input logic [7:0] bytes[$]);
        cs_low();
        foreach (bytes[i]) send_byte(bytes[i]);
        cs_high();
    endtask

    task automatic check_txq(input string name);
        check({name, " count"}, txq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) check({name, " byte"}, q_at(i), exp_q[i]);
    endtask

    typedef struct {
        logic [7:0] b0, b1, st, e0, e1, fan, ctl;
    } vec_t;
    vec_t vecs[6];

    initial begin
        logic [7:0] fr[$];
        int         lat;

        vecs[0] = '{8'h81, 8'h40, 8'h5C, 8'h00, 8'h40, 8'h40, 8'h00};
        vecs[1] = '{8'h00, 8'hFF, 8'h5C, 8'hA5, AUTOINC ? 8'h40 : 8'hA5, 8'h40, 8'h00};
        vecs[2] = '{8'h82, 8'h3C, 8'h5C, 8'h00, 8'h3C, 8'h40, 8'h3C};
        vecs[3] = '{8'h02, 8'h00, 8'h5C, 8'h3C, AUTOINC ? 8'h5C : 8'h3C, 8'h40, 8'h3C};
        vecs[4] = '{8'h83, 8'h12, 8'h5C, 8'h00, 8'h12, 8'h40, 8'h3C};
        vecs[5] = '{8'h03, 8'h00, 8'h5C, 8'h5C, AUTOINC ? 8'h00 : 8'h5C, 8'h40, 8'h3C};

        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        reset = 1'b1; spiCS = 1'b1; rxReady = 1'b0; rx = 8'h00; status = 8'h00;
        repeat (3) @(negedge sysclk);
        check("reset tx", tx, 8'h00);
        check("reset txReady", txReady, 1'b0);
        check("reset fanDuty", fanDuty, 8'h00);
        check("reset ctrl", ctrl, 8'h00);
        reset = 1'b0;
        repeat (4) @(negedge sysclk);

        for (int i = 0; i < 6; i++) begin
            status = vecs[i].st;
            fr = '{vecs[i].b0, vecs[i].b1};
            model_frame(fr);
            run_frame(fr);
            check("vec count", txq.size(), 2);
            check("vec tx0", q_at(0), vecs[i].e0);
            check("vec tx1", q_at(1), vecs[i].e1);
            check("vec fanDuty", fanDuty, vecs[i].fan);
            check("vec ctrl", ctrl, vecs[i].ctl);
        end

        // Read-ID latency measured from the raw rxReady rise.
        cs_low();
        @(negedge sysclk);
        rx = 8'h00;
        rxReady = 1'b1;
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sysclk);
            if (txReady && lat < 0) lat = i + 1;
        end
        rxReady = 1'b0;
        repeat (4) @(negedge sysclk);
        send_byte(8'hFF);
        cs_high();
        check("id latency ok", (lat > 0 && lat <= SS + 2), 1'b1);
        check("id tx", q_at(0), 8'hA5);

        // Burst write at the top of the map.
        status = 8'h5C;
        fr = '{8'h8F, 8'h11, 8'h22};
        model_frame(fr);
        run_frame(fr);
        check_txq("burst echo");
        fr = '{8'h0F, 8'h00};
        run_frame(fr);
        check("burst reg15", q_at(0), AUTOINC ? 8'h11 : 8'h22);
        check("burst next", q_at(1), AUTOINC ? 8'hA5 : 8'h22);

        // CS rises together with a data byte: byte dropped, no pulse.
        cs_low();
        send_byte(8'h81);
        @(negedge sysclk);
        rx = 8'h77;
        rxReady = 1'b1;
        spiCS = 1'b1;
        repeat (4) @(negedge sysclk);
        rxReady = 1'b0;
        repeat (SS + 4) @(negedge sysclk);
        check("abort pulses", txq.size(), 1);
        check("abort fanDuty", fanDuty, 8'h40);
        fr = '{8'h01, 8'h00};
        run_frame(fr);
        check("abort next cmd", q_at(0), 8'h40);

        for (int n = 0; n < 20; n++) begin
            int nd;
            nd = $urandom_range(1, 3);
            status = 8'($urandom);
            fr.delete();
            fr.push_back(8'($urandom));
            for (int i = 0; i < nd; i++) fr.push_back(8'($urandom));
            model_frame(fr);
            run_frame(fr);
            check_txq("rand tx");
            check("rand fanDuty", fanDuty, m_regs[1]);
            check("rand ctrl", ctrl, m_regs[2]);
        end

        // Reset mid-WRITE with CS held low: trailing byte must be ignored.
        cs_low();
        send_byte(8'h82);
        @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        txq.delete();
        send_byte(8'h99);
        check("rst pulses", txq.size(), 0);
        check("rst ctrl", ctrl, 8'h00);
        cs_high();
        status = 8'h3E;
        fr = '{8'h02, 8'h00};
        model_frame(fr);
        run_frame(fr);
        check_txq("post rst");
        check("post rst ctrl rd", q_at(0), 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
